rx_sd_hyst: RTL and testbench
=============================

Name: rx_sd_hyst

Overview:
Second-generation received-signal strength detector for the baseband I/Q path.
- Computes a per-sample level from |I|,|Q| in one of two selectable modes: instantaneous peak, or moving average over 2^AVG_LOG2 samples.
- Applies a two-threshold hysteresis state machine with separate assert and release qualification counts.
- Drives SD_flag, plus rise/fall pulses and the level itself, to the downstream Rx sync/control logic.

Parameters:
WIDTH, 16, sample width of I/Q and of thresholds/level
MAX_WINDOW_WIDTH, 8, width of the qualification count inputs
AVG_LOG2, 4, log2 of the moving-average depth (1..8)

Ports:
clk  in  1  sample-domain clock (16.384 MHz)
rst  in  1  synchronous, active-high reset
RX_SD_MODE  in  1  0 = peak level, 1 = moving-average level
RX_SD_TH_ON  in  WIDTH  assert threshold (unsigned)
RX_SD_TH_OFF  in  WIDTH  release threshold (unsigned)
RX_SD_ON_CNT  in  MAX_WINDOW_WIDTH  consecutive qualifying samples needed to assert
RX_SD_OFF_CNT  in  MAX_WINDOW_WIDTH  consecutive sub-threshold samples needed to release
I_tdata  in  WIDTH  signed I sample
I_tvalid  in  1  I valid
Q_tdata  in  WIDTH  signed Q sample
Q_tvalid  in  1  Q valid
SD_level  out  WIDTH  current level (unsigned)
SD_level_valid  out  1  one-cycle strobe, SD_level updated
SD_flag  out  1  signal-present flag
SD_rise  out  1  one-cycle pulse on flag 0->1
SD_fall  out  1  one-cycle pulse on flag 1->0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, FSM IDLE, counters 0, average buffer and running sum cleared.
- Sample acceptance: a sample is accepted only when I_tvalid && Q_tvalid in the same cycle. Otherwise the pipeline and counters hold.
- Stage 1 (reg): a = max(|I|,|Q|), unsigned WIDTH bits. -2^(WIDTH-1) maps to 2^(WIDTH-1) with no saturation.
- Stage 2 (reg), both modes computed every accepted sample:
  - Peak mode: level = a.
  - Average mode: circular buffer of 2^AVG_LOG2 entries. sum <= sum + a_new - a_oldest, with sum width WIDTH+AVG_LOG2 so it never overflows. level = sum >> AVG_LOG2 (truncate).
  - RX_SD_MODE only muxes the output, so a mode change needs no flush.
- Latency: accepted sample -> SD_level_valid 2 cycles. SD_flag/SD_rise/SD_fall update 1 cycle after SD_level_valid (3 total).
- Threshold rules: effective off threshold TH_OFF' = min(TH_OFF, TH_ON). Effective counts N_on = max(ON_CNT,1) and N_off = max(OFF_CNT,1).
- FSM, evaluated only on SD_level_valid cycles:
  - IDLE: if level >= TH_ON, set cnt=1. If N_on==1, go ACTIVE; else go ARMING.
  - ARMING: if level >= TH_ON, cnt++. When cnt==N_on, go ACTIVE (SD_rise). If level < TH_ON, go IDLE with cnt=0.
  - ACTIVE: if level < TH_OFF', set cnt=1. If N_off==1, go IDLE (SD_fall); else go RELEASING.
  - RELEASING: if level < TH_OFF', cnt++. When cnt==N_off, go IDLE (SD_fall). If level >= TH_OFF', go ACTIVE with cnt=0.
- SD_flag = 1 in ACTIVE and RELEASING.
- cnt is MAX_WINDOW_WIDTH bits. It cannot wrap because every transition fires at equality.
- Config inputs are live. Changes take effect at the next evaluation; cnt is not cleared.
- Reset mid-operation: flag drops the next cycle with no SD_fall pulse. Average history is discarded.
- During buffer fill after reset, empty slots count as 0, so the average-mode level ramps up.

Decomposition:
- Package rx_sd_pkg: FSM state enum (IDLE, ARMING, ACTIVE, RELEASING) and SUM_WIDTH = WIDTH+AVG_LOG2 helper constant.
- Sub-module rx_sd_movavg: circular buffer, running sum and shift, with accept-enable input.

Test Plan:
1. Reset: rst high 2 cycles with I=20000 valid -> all outputs 0. First SD_level_valid appears 2 cycles after the first accepted post-reset sample.
2. Peak mode, TH_ON=1000, TH_OFF=500, ON_CNT=3, OFF_CNT=4; I=1200,Q=0 continuous -> SD_level=1200; SD_rise single pulse and SD_flag=1 five cycles after the first accepted sample; I=999 after 2 samples instead -> flag stays 0.
3. Hysteresis, same config, flag high: level 700 for 100 samples -> flag stays 1; 3x400 then 700 -> no fall; 4x400 -> SD_fall pulse, flag 0.
4. Extremes: I=-32768, Q=100, peak mode -> SD_level=32768; TH_OFF=2000 > TH_ON=1000 -> release uses 1000.
5. Average mode, AVG_LOG2=4, TH_ON=1000, ON_CNT=1; from reset, I=1600 constant -> level ramps 100,200,...,1600; flag asserts on the 10th level (1000).
6. Valid gaps: Q_tvalid low on alternate cycles -> only paired-valid samples counted, level and cnt frozen on gaps; rst pulse while ACTIVE -> flag 0 next cycle, no SD_fall.

Source files
------------

// File: rtl/rx_sd_pkg.sv
// rx_sd_pkg: shared FSM state type and width helpers for the rx_sd_hyst signal detector
package rx_sd_pkg;
  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} sd_state_t;
  localparam int WIDTH_DEF = 16;
  localparam int AVG_LOG2_DEF = 4;
  localparam int SUM_WIDTH = WIDTH_DEF + AVG_LOG2_DEF;
  function automatic int sum_width(input int w, input int l);
    return w + l;
  endfunction
endpackage

// File: rtl/rx_sd_movavg.sv
// rx_sd_movavg: 2^AVG_LOG2-deep moving average (clk, rst, en accept strobe, a sample in, avg level out)
module rx_sd_movavg
  import rx_sd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] avg
);
  localparam int SW = sum_width(WIDTH, AVG_LOG2);
  localparam int DEPTH = 1 << AVG_LOG2;
  logic [WIDTH-1:0] hist [DEPTH];
  logic [AVG_LOG2-1:0] ptr;
  logic [SW-1:0] sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      sum <= '0;
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (en) begin
      hist[ptr] <= a;
      sum <= sum + SW'(a) - SW'(hist[ptr]);
      ptr <= ptr + AVG_LOG2'(1);
    end
  end
  assign avg = WIDTH'(sum >> AVG_LOG2);
endmodule

// File: rtl/rx_sd_hyst.sv
// rx_sd_hyst: I/Q signal detector (peak/avg level, hysteresis FSM) -> SD_level(_valid), SD_flag, SD_rise, SD_fall
module rx_sd_hyst
  import rx_sd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int AVG_LOG2 = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        RX_SD_MODE,
  input  logic [WIDTH-1:0]            RX_SD_TH_ON,
  input  logic [WIDTH-1:0]            RX_SD_TH_OFF,
  input  logic [MAX_WINDOW_WIDTH-1:0] RX_SD_ON_CNT,
  input  logic [MAX_WINDOW_WIDTH-1:0] RX_SD_OFF_CNT,
  input  logic [WIDTH-1:0]            I_tdata,
  input  logic                        I_tvalid,
  input  logic [WIDTH-1:0]            Q_tdata,
  input  logic                        Q_tvalid,
  output logic [WIDTH-1:0]            SD_level,
  output logic                        SD_level_valid,
  output logic                        SD_flag,
  output logic                        SD_rise,
  output logic                        SD_fall
);
  logic accept, a_v, hi, lo;
  logic [WIDTH-1:0] abs_i, abs_q, a_r, peak, avg, th_off_eff;
  logic [MAX_WINDOW_WIDTH-1:0] cnt, cnt_up, n_on, n_off;
  sd_state_t state;
  always_comb begin
    accept = I_tvalid & Q_tvalid;
    abs_i = I_tdata[WIDTH-1] ? -I_tdata : I_tdata;
    abs_q = Q_tdata[WIDTH-1] ? -Q_tdata : Q_tdata;
    th_off_eff = (RX_SD_TH_OFF < RX_SD_TH_ON) ? RX_SD_TH_OFF : RX_SD_TH_ON;
    n_on = (RX_SD_ON_CNT == '0) ? MAX_WINDOW_WIDTH'(1) : RX_SD_ON_CNT;
    n_off = (RX_SD_OFF_CNT == '0) ? MAX_WINDOW_WIDTH'(1) : RX_SD_OFF_CNT;
    hi = SD_level >= RX_SD_TH_ON;
    lo = SD_level < th_off_eff;
    cnt_up = cnt + MAX_WINDOW_WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      a_v <= 1'b0;
      peak <= '0;
      SD_level_valid <= 1'b0;
    end else begin
      a_v <= accept;
      SD_level_valid <= a_v;
      if (accept) a_r <= (abs_i > abs_q) ? abs_i : abs_q;
      if (a_v) peak <= a_r;
    end
  end
  rx_sd_movavg #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk(clk),
    .rst(rst),
    .en(a_v),
    .a(a_r),
    .avg(avg)
  );
  assign SD_level = RX_SD_MODE ? avg : peak;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      SD_flag <= 1'b0;
      SD_rise <= 1'b0;
      SD_fall <= 1'b0;
    end else begin
      SD_rise <= 1'b0;
      SD_fall <= 1'b0;
      if (SD_level_valid) begin
        case (state)
          IDLE, ARMING:
            if (!hi) begin
              state <= IDLE;
              cnt <= '0;
            end else if (cnt_up >= n_on) begin
              state <= ACTIVE;
              cnt <= '0;
              SD_flag <= 1'b1;
              SD_rise <= 1'b1;
            end else begin
              state <= ARMING;
              cnt <= cnt_up;
            end
          default:
            if (!lo) begin
              state <= ACTIVE;
              cnt <= '0;
            end else if (cnt_up >= n_off) begin
              state <= IDLE;
              cnt <= '0;
              SD_flag <= 1'b0;
              SD_fall <= 1'b1;
            end else begin
              state <= RELEASING;
              cnt <= cnt_up;
            end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_sd_hyst.sv
// tb_rx_sd_hyst: randomized and directed checks of rx_sd_hyst against a run-length reference model
module tb_rx_sd_hyst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic [15:0] th_on = 16'd1000;
  logic [15:0] th_off = 16'd500;
  logic [7:0] on_cnt = 8'd3;
  logic [7:0] off_cnt = 8'd4;
  logic [15:0] i_d = '0;
  logic [15:0] q_d = '0;
  logic i_v = 1'b0;
  logic q_v = 1'b0;
  logic [15:0] SD_level;
  logic SD_level_valid, SD_flag, SD_rise, SD_fall;
  rx_sd_hyst dut (
    .clk(clk),
    .rst(rst),
    .RX_SD_MODE(mode),
    .RX_SD_TH_ON(th_on),
    .RX_SD_TH_OFF(th_off),
    .RX_SD_ON_CNT(on_cnt),
    .RX_SD_OFF_CNT(off_cnt),
    .I_tdata(i_d),
    .I_tvalid(i_v),
    .Q_tdata(q_d),
    .Q_tvalid(q_v),
    .SD_level(SD_level),
    .SD_level_valid(SD_level_valid),
    .SD_flag(SD_flag),
    .SD_rise(SD_rise),
    .SD_fall(SD_fall)
  );
  always #5 clk = ~clk;
  typedef struct {bit v; int peak; int avg;} samp_t;
  samp_t p1, p2;
  int hist[$];
  bit mflag;
  int run_on, run_off;
  logic [19:0] exp_v, got_v;
  int nvec, nerr;
  function automatic int lvl_of(samp_t s);
    return mode ? s.avg : s.peak;
  endfunction
  task automatic step(input int i, input int q, input bit iv, input bit qv, input bit r);
    samp_t cur;
    int ai, aq, s, lv, tf, non, noff;
    bit rise, fall;
    rst = r;
    i_d = i[15:0];
    q_d = q[15:0];
    i_v = iv;
    q_v = qv;
    cur.v = iv && qv && !r;
    cur.peak = 0;
    cur.avg = 0;
    if (cur.v) begin
      ai = (i < 0) ? -i : i;
      aq = (q < 0) ? -q : q;
      cur.peak = (ai > aq) ? ai : aq;
      hist.push_back(cur.peak);
      if (hist.size() > 16) void'(hist.pop_front());
      s = 0;
      foreach (hist[k]) s += hist[k];
      cur.avg = s / 16;
    end
    @(posedge clk);
    #1;
    rise = 0;
    fall = 0;
    if (r) begin
      hist.delete();
      mflag = 0;
      run_on = 0;
      run_off = 0;
      p1.v = 0;
      p2.v = 0;
      exp_v = '0;
    end else begin
      if (p2.v) begin
        lv = lvl_of(p2);
        tf = (int'(th_off) < int'(th_on)) ? int'(th_off) : int'(th_on);
        non = (on_cnt == 0) ? 1 : int'(on_cnt);
        noff = (off_cnt == 0) ? 1 : int'(off_cnt);
        if (!mflag) begin
          run_on = (lv >= int'(th_on)) ? run_on + 1 : 0;
          if (run_on >= non) begin
            mflag = 1;
            rise = 1;
            run_on = 0;
          end
        end else begin
          run_off = (lv < tf) ? run_off + 1 : 0;
          if (run_off >= noff) begin
            mflag = 0;
            fall = 1;
            run_off = 0;
          end
        end
      end
      exp_v = {p1.v, p1.v ? 16'(lvl_of(p1)) : 16'd0, mflag, rise, fall};
      p2 = p1;
      p1 = cur;
    end
    got_v = {SD_level_valid, SD_level_valid ? SD_level : 16'd0, SD_flag, SD_rise, SD_fall};
  endtask
  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask
  task automatic test_reset();
    step(20000, 0, 1, 1, 1);
    step(20000, 0, 1, 1, 1);
    nvec++;
    if (got_v !== 20'd0) begin
      nerr++;
      $display("FAIL reset_outputs got=%h exp=0", got_v);
    end
    step(20000, 0, 1, 1, 0);
    nvec++;
    if (SD_level_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_latency1 got=%b exp=0", SD_level_valid);
    end
    step(0, 0, 0, 0, 0);
    nvec++;
    if (SD_level_valid !== 1'b1 || SD_level !== 16'd20000) begin
      nerr++;
      $display("FAIL reset_latency2 got=%b/%0d exp=1/20000", SD_level_valid, SD_level);
    end
    nvec++;
    if (got_v !== exp_v) begin
      nerr++;
      $display("FAIL reset_model got=%h exp=%h", got_v, exp_v);
    end
  endtask
  task automatic test_peak();
    mode = 0;
    th_on = 1000;
    th_off = 500;
    on_cnt = 3;
    off_cnt = 4;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      step(1200, 0, 1, 1, 0);
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL peak_model n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
      if (n == 4 || n == 5 || n == 6) begin
        nvec++;
        if ({SD_flag, SD_rise} !== ((n == 4) ? 2'b00 : (n == 5) ? 2'b11 : 2'b10)) begin
          nerr++;
          $display("FAIL peak_rise n=%0d got=%b%b", n, SD_flag, SD_rise);
        end
      end
    end
    nvec++;
    if (SD_level !== 16'd1200) begin
      nerr++;
      $display("FAIL peak_level got=%0d exp=1200", SD_level);
    end
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      step((n <= 2) ? 1200 : 999, 0, 1, 1, 0);
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL peak_short n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
    end
    nvec++;
    if (SD_flag !== 1'b0) begin
      nerr++;
      $display("FAIL peak_short_flag got=%b exp=0", SD_flag);
    end
  endtask
  task automatic test_hyst();
    int falls;
    do_reset();
    falls = 0;
    for (int n = 0; n < 6; n++) step(1200, 0, 1, 1, 0);
    for (int n = 0; n < 116; n++) begin
      step((n >= 100 && n < 103) ? 400 : 700, 0, 1, 1, 0);
      falls += SD_fall;
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL hyst_hold n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
    end
    nvec++;
    if (SD_flag !== 1'b1 || falls != 0) begin
      nerr++;
      $display("FAIL hyst_nofall got=%b/%0d exp=1/0", SD_flag, falls);
    end
    for (int n = 0; n < 8; n++) begin
      step((n < 4) ? 400 : 0, 0, n < 4, n < 4, 0);
      falls += SD_fall;
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL hyst_release n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
    end
    nvec++;
    if (SD_flag !== 1'b0 || falls != 1) begin
      nerr++;
      $display("FAIL hyst_fall got=%b/%0d exp=0/1", SD_flag, falls);
    end
  endtask
  task automatic test_extremes();
    do_reset();
    th_off = 2000;
    for (int n = 0; n < 22; n++) begin
      step((n < 6) ? -32768 : (n < 16) ? 1200 : 999, (n < 6) ? 100 : 0, 1, 1, 0);
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL ext_model n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
      if (n == 2) begin
        nvec++;
        if (SD_level !== 16'd32768) begin
          nerr++;
          $display("FAIL ext_level got=%0d exp=32768", SD_level);
        end
      end
      if (n == 18) begin
        nvec++;
        if (SD_flag !== 1'b1) begin
          nerr++;
          $display("FAIL ext_thoff_clamp got=%b exp=1", SD_flag);
        end
      end
    end
    nvec++;
    if (SD_flag !== 1'b0) begin
      nerr++;
      $display("FAIL ext_release got=%b exp=0", SD_flag);
    end
    th_off = 500;
  endtask
  task automatic test_avg();
    int nlv, rise_at;
    mode = 1;
    on_cnt = 1;
    do_reset();
    nlv = 0;
    rise_at = -1;
    for (int n = 0; n < 24; n++) begin
      step(1600, 0, n < 20, n < 20, 0);
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL avg_model n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
      if (SD_rise === 1'b1) rise_at = nlv;
      if (SD_level_valid === 1'b1) begin
        nlv++;
        nvec++;
        if (SD_level !== 16'(((nlv < 16) ? nlv : 16) * 100)) begin
          nerr++;
          $display("FAIL avg_ramp k=%0d got=%0d exp=%0d", nlv, SD_level, ((nlv < 16) ? nlv : 16) * 100);
        end
      end
    end
    nvec++;
    if (rise_at != 10) begin
      nerr++;
      $display("FAIL avg_assert got=%0d exp=10", rise_at);
    end
    mode = 0;
    on_cnt = 3;
  endtask
  task automatic test_gaps();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      step(int'($urandom_range(0, 3000)), int'($urandom_range(0, 600)), 1, n % 2 == 0, 0);
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL gaps_model n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
    end
    for (int n = 0; n < 16; n++) step(1500, 0, 1, n % 2 == 0, 0);
    nvec++;
    if (SD_flag !== 1'b1) begin
      nerr++;
      $display("FAIL gaps_active got=%b exp=1", SD_flag);
    end
    step(1500, 0, 1, 1, 1);
    nvec++;
    if (SD_flag !== 1'b0 || SD_fall !== 1'b0) begin
      nerr++;
      $display("FAIL gaps_rst got=%b%b exp=00", SD_flag, SD_fall);
    end
  endtask
  task automatic test_random();
    int mag, iv, qv;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        th_on = 16'($urandom_range(0, 16000));
        th_off = 16'($urandom_range(0, 16000));
        on_cnt = 8'($urandom_range(0, 5));
        off_cnt = 8'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      mag = ($urandom_range(0, 9) == 0) ? 32767 : 2 * int'(th_on) + 1;
      iv = int'($urandom_range(0, mag));
      qv = int'($urandom_range(0, mag));
      if ($urandom_range(0, 1) == 1) iv = -iv;
      if ($urandom_range(0, 1) == 1) qv = -qv;
      if ($urandom_range(0, 50) == 0) iv = -32768;
      step(iv, qv, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 599) == 0);
      nvec++;
      if (got_v !== exp_v) begin
        nerr++;
        $display("FAIL random n=%0d got=%h exp=%h", n, got_v, exp_v);
      end
    end
  endtask
  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_peak();
    test_hyst();
    test_extremes();
    test_avg();
    test_gaps();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
